// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan chain sequencer.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } scan_state_t;

  localparam int                    FAIL_CNT_W   = 8;
  localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = 8'd255;

  function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
    return (v == FAIL_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/scan_unload_sr.sv
// Serial-in/parallel-out shift register with enable, filled MSB-first from ser_i.
// par_next_o is the value held after the current edge if shifting, so a caller can use the final sample without waiting a cycle.
module scan_unload_sr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] par_next_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = {sr_q[WIDTH-2:0], ser_i};
  end

  // NOTE: a full unload overwrites every bit, so reset is not needed for correctness; it keeps the register deterministic after rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q <= '0;
    end else if (en_i) begin
      sr_q <= sr_d;
    end
  end

  assign par_next_o = sr_d;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Sequencer for one mux-scan chain: serial load, single capture, serial unload with compare.
// Keeps the last response, a pass flag and a saturating fail count.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  clr_fail,
  input  logic [CHAIN_LEN-1:0]  pattern,
  input  logic [CHAIN_LEN-1:0]  expected,
  input  logic                  scan_out,
  output logic                  scan_en,
  output logic                  scan_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CHAIN_LEN-1:0]  response,
  output logic [FAIL_CNT_W-1:0] fail_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  scan_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0]   pat_q, pat_d;
  logic [CHAIN_LEN-1:0]   exp_q, exp_d;
  logic                   pass_q, pass_d;
  logic [CHAIN_LEN-1:0]   resp_q, resp_d;
  logic [FAIL_CNT_W-1:0]  fail_q, fail_d;
  logic                   cnt_last;
  logic                   unload_en;
  logic                   result_upd;
  logic [CHAIN_LEN-1:0]   sr_next;

  assign cnt_last = (cnt_q == CNT_LAST);

  scan_unload_sr #(
    .WIDTH(CHAIN_LEN)
  ) u_response_sr (
    .clk        (clk),
    .rst        (rst),
    .en_i       (unload_en),
    .ser_i      (scan_out),
    .par_next_o (sr_next)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    exp_d     = exp_q;
    unload_en = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT_IN;
          cnt_d   = '0;
          pat_d   = pattern;
          exp_d   = expected;
        end
      end
      SHIFT_IN: begin
        pat_d = pat_q << 1;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        cnt_d   = '0;
        state_d = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        unload_en = 1'b1;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
    end
  end

  // Results are registered on the edge entering DONE so they are already valid while done is high.
  assign result_upd = (state_q == SHIFT_OUT) && cnt_last && !abort;

  always_comb begin
    pass_d = pass_q;
    resp_d = resp_q;
    fail_d = fail_q;
    if (result_upd) begin
      resp_d = sr_next;
      pass_d = (sr_next == exp_q);
      if (sr_next != exp_q) begin
        fail_d = sat_inc(fail_q);
      end
    end
    if (clr_fail) begin
      fail_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
      resp_q  <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
      resp_q  <= resp_d;
      fail_q  <= fail_d;
    end
  end

  assign scan_en  = (state_q == SHIFT_IN) || (state_q == SHIFT_OUT);
  assign scan_in  = (state_q == SHIFT_IN) && pat_q[CHAIN_LEN-1];
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign pass     = pass_q;
  assign response = resp_q;
  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl driving an 8-flop mux-scan chain model.
module tb_scan_chain_ctrl;

  localparam int N = 8;

  typedef struct {
    logic [N-1:0] pattern;
    logic [N-1:0] d;
    logic [N-1:0] expected;
    logic         exp_pass;
    logic [N-1:0] exp_resp;
    logic [7:0]   exp_fail;
    logic         clr;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         clr_fail = 1'b0;
  logic [N-1:0] pattern = '0;
  logic [N-1:0] expected = '0;
  logic         scan_out;
  logic         scan_en, scan_in, busy, done, pass;
  logic [N-1:0] response;
  logic [7:0]   fail_cnt;
  logic [N-1:0] chain = '0;
  logic [N-1:0] d_vec = '0;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t vecs [8];

  always #5 clk = ~clk;

  // Mux-scan chain: flop 0 takes scan_in, flop k takes flop k-1, flop N-1 drives scan_out.
  assign scan_out = chain[N-1];
  always @(posedge clk) chain <= scan_en ? {chain[N-2:0], scan_in} : d_vec;

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .clr_fail (clr_fail),
    .pattern  (pattern),
    .expected (expected),
    .scan_out (scan_out),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .response (response),
    .fail_cnt (fail_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; starts a test immediately and checks it through done.
  task automatic run_test(input vec_t v);
    int           cyc;
    int           lat;
    logic [N-1:0] sin_seq;
    logic [N-1:0] chain_snap;
    logic [16:0]  se_seq;
    logic [16:0]  se_exp;
    logic         fill_bad;
    pattern  = v.pattern;
    expected = v.expected;
    d_vec    = v.d;
    start    = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    cyc        = 1;
    lat        = 0;
    sin_seq    = '0;
    chain_snap = '0;
    se_seq     = '0;
    fill_bad   = 1'b0;
    while (lat == 0 && cyc <= 40) begin
      clr_fail = v.clr && (cyc >= 17);
      if (cyc <= 8) sin_seq = {sin_seq[N-2:0], scan_in};
      if (cyc >= 9 && cyc <= 17 && scan_in) fill_bad = 1'b1;
      if (cyc <= 17) se_seq = {se_seq[15:0], scan_en};
      if (cyc == 9) chain_snap = chain;
      if (done) begin
        lat = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    clr_fail = 1'b0;
    se_exp   = {8'hFF, 1'b0, 8'hFF};
    check("latency", lat, 18);
    check("scan_in_seq", sin_seq, v.pattern);
    check("scan_en_seq", se_seq, se_exp);
    check("zero_fill", fill_bad, 0);
    check("chain_loaded", chain_snap, v.pattern);
    check("pass", pass, v.exp_pass);
    check("response", response, v.exp_resp);
    check("fail_cnt", fail_cnt, v.exp_fail);
    check("busy_in_done", busy, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("response_hold", response, v.exp_resp);
    check("pass_hold", pass, v.exp_pass);
  endtask

  initial begin
    int n_done;
    int first;
    int cyc;
    int last;
    int gap_bad;

    vecs[0] = '{8'hA5, 8'h3C, 8'h3C, 1'b1, 8'h3C, 8'd0, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 8'h00, 1'b1, 8'h00, 8'd0, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'd0, 1'b0};
    vecs[3] = '{8'h5A, 8'h3C, 8'h3D, 1'b0, 8'h3C, 8'd1, 1'b0};
    vecs[4] = '{8'h81, 8'h81, 8'h81, 1'b1, 8'h81, 8'd1, 1'b0};
    vecs[5] = '{8'h12, 8'hC3, 8'hC2, 1'b0, 8'hC3, 8'd2, 1'b0};
    vecs[6] = '{8'hA5, 8'h3C, 8'h3C, 1'b1, 8'h3C, 8'd2, 1'b0};
    vecs[7] = '{8'h6E, 8'h3C, 8'h3D, 1'b0, 8'h3C, 8'd0, 1'b1};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scan_en", scan_en, 0);
    check("rst_scan_in", scan_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_response", response, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_test(vecs[i]);

    // Abort in SHIFT_IN, then restart on the very next idle cycle.
    pattern  = 8'hF0;
    d_vec    = 8'h0F;
    expected = 8'h0F;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_scan_en", scan_en, 0);
    check("abort_pass_kept", pass, 0);
    check("abort_response_kept", response, 8'hC3);
    check("abort_fail_kept", fail_cnt, 2);
    run_test(vecs[6]);

    // start pulsed during CAPTURE must be ignored.
    pattern  = 8'h3C;
    d_vec    = 8'h96;
    expected = 8'h96;
    start    = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    n_done = 0;
    first  = 0;
    for (int c = 1; c <= 45; c++) begin
      start = (c == 9);
      if (done) begin
        n_done++;
        if (first == 0) first = c;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_start_done_count", n_done, 1);
    check("busy_start_latency", first, 18);
    check("busy_start_response", response, 8'h96);
    check("busy_start_pass", pass, 1);

    run_test(vecs[7]);

    // Back-to-back failing tests with start held high; fail_cnt saturates.
    pattern  = 8'h00;
    d_vec    = 8'h3C;
    expected = 8'h3D;
    start    = 1'b1;
    cyc      = 0;
    n_done   = 0;
    last     = 0;
    gap_bad  = 0;
    while (n_done < 260 && cyc < 260 * 19 + 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        n_done++;
        if (n_done > 1 && (cyc - last) != 19) gap_bad++;
        last = cyc;
        if (n_done == 1)   check("sat_cnt_1", fail_cnt, 1);
        if (n_done == 254) check("sat_cnt_254", fail_cnt, 254);
        if (n_done == 255) check("sat_cnt_255", fail_cnt, 255);
        if (n_done == 260) begin
          check("sat_cnt_260", fail_cnt, 255);
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("sat_done_count", n_done, 260);
    check("sat_start_interval", gap_bad, 0);
    @(negedge clk);

    // Reset asserted in the third SHIFT_OUT cycle.
    pattern  = 8'h5A;
    d_vec    = 8'h77;
    expected = 8'h77;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_scan_en", scan_en, 0);
    check("midrst_scan_in", scan_in, 0);
    check("midrst_done", done, 0);
    check("midrst_response", response, 0);
    check("midrst_pass", pass, 0);
    check("midrst_fail_cnt", fail_cnt, 0);
    rst    = 1'b1;
    n_done = 0;
    repeat (25) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("midrst_no_done", n_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
